// File: rtl/float_pkg.sv
// Shared IEEE-754 single-precision field layout and constants for the float datapath.
package float_pkg;

    localparam int F32_EXP_W       = 8;
    localparam int F32_MAN_W       = 23;
    localparam int F32_EXP_BIAS    = 127;
    localparam logic [F32_EXP_W-1:0] F32_EXP_SPECIAL = 8'hFF;

    // A right shift of 26 moves every mantissa bit (plus hidden one) below the
    // guard and round positions, so anything larger gives the same G/R/S result.
    localparam int F32_MAX_RSHIFT  = 26;

    typedef struct packed {
        logic                 sign;
        logic [F32_EXP_W-1:0] exp;
        logic [F32_MAN_W-1:0] frac;
    } float32_t;

endpackage

// File: rtl/float_to_int_nb.sv
// Four-stage non-blocking float32 -> signed fixed-point converter with
// round-to-nearest-even and output saturation. One operand per cycle, no stalls.
module float_to_int_nb
    import float_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    output logic             dout_sat
);

    localparam int MAN24_W = F32_MAN_W + 1;
    localparam int MAG_W   = OUT_W + 1;
    localparam int WIDE_W  = MAN24_W + F32_MAX_RSHIFT;

    // Magnitude 2^(OUT_W-1): the largest negative magnitude that still fits.
    localparam logic [MAG_W-1:0] LIM     = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

    // ---------------- stage 1: unpack ----------------
    float32_t            f_in;
    logic                s1_zero_n;
    logic                s1_special_n;
    logic signed [9:0]   s1_e_n;

    logic                s1_valid;
    logic                s1_sign;
    logic [MAN24_W-1:0]  s1_man;
    logic signed [9:0]   s1_e;
    logic                s1_zero;
    logic                s1_inf;
    logic                s1_nan;

    // Decode the raw fields and the unbiased exponent, already offset by FRAC_W.
    always_comb begin
        f_in         = float32_t'(din);
        s1_zero_n    = (f_in.exp == '0);
        s1_special_n = (f_in.exp == F32_EXP_SPECIAL);
        s1_e_n       = $signed({2'b00, f_in.exp}) - $signed(10'(F32_EXP_BIAS))
                       + $signed(10'(FRAC_W));
    end

    // Stage 1 register: data loads only for a valid operand, valid always advances.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_man   <= '0;
            s1_e     <= '0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
            s1_nan   <= 1'b0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_sign <= f_in.sign;
                s1_man  <= {~s1_zero_n, f_in.frac};
                s1_e    <= s1_e_n;
                s1_zero <= s1_zero_n;
                s1_inf  <= s1_special_n & ~(|f_in.frac);
                s1_nan  <= s1_special_n & (|f_in.frac);
            end
        end
    end

    // ---------------- stage 2: align ----------------
    logic [9:0]          rsh_raw;
    logic [4:0]          rsh;
    logic [9:0]          lsh;
    logic [WIDE_W-1:0]   wide;
    logic [MAG_W-1:0]    s2_mag_n;
    logic                s2_g_n;
    logic                s2_r_n;
    logic                s2_s_n;
    logic                s2_ovf_n;

    logic                s2_valid;
    logic                s2_sign;
    logic [MAG_W-1:0]    s2_mag;
    logic                s2_g;
    logic                s2_r;
    logic                s2_s;
    logic                s2_ovf;
    logic                s2_inf;
    logic                s2_nan;

    // Shift the mantissa so the binary point sits below bit 0, capturing G/R/S.
    always_comb begin
        rsh_raw  = '0;
        rsh      = '0;
        lsh      = '0;
        wide     = '0;
        s2_mag_n = '0;
        s2_g_n   = 1'b0;
        s2_r_n   = 1'b0;
        s2_s_n   = 1'b0;
        s2_ovf_n = 1'b0;
        if (s1_zero || s1_inf || s1_nan) begin
            s2_mag_n = '0;
        end else if (s1_e >= $signed(10'(OUT_W))) begin
            s2_ovf_n = 1'b1;
        end else if (s1_e <= 10'sd23) begin
            rsh_raw  = 10'(10'sd23 - s1_e);
            rsh      = (rsh_raw > 10'(F32_MAX_RSHIFT)) ? 5'(F32_MAX_RSHIFT) : rsh_raw[4:0];
            wide     = {s1_man, {F32_MAX_RSHIFT{1'b0}}} >> rsh;
            s2_mag_n = MAG_W'(wide[WIDE_W-1 -: MAN24_W]);
            s2_g_n   = wide[F32_MAX_RSHIFT-1];
            s2_r_n   = wide[F32_MAX_RSHIFT-2];
            s2_s_n   = |wide[F32_MAX_RSHIFT-3:0];
        end else begin
            lsh      = 10'(s1_e - 10'sd23);
            s2_mag_n = MAG_W'(s1_man) << lsh;
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_g     <= 1'b0;
            s2_r     <= 1'b0;
            s2_s     <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_nan   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                s2_mag  <= s2_mag_n;
                s2_g    <= s2_g_n;
                s2_r    <= s2_r_n;
                s2_s    <= s2_s_n;
                s2_ovf  <= s2_ovf_n;
                s2_inf  <= s1_inf;
                s2_nan  <= s1_nan;
            end
        end
    end

    // ---------------- stage 3: round to nearest even ----------------
    logic                round_up;
    logic [MAG_W-1:0]    s3_mag_n;

    logic                s3_valid;
    logic                s3_sign;
    logic [MAG_W-1:0]    s3_mag;
    logic                s3_ovf;
    logic                s3_inf;
    logic                s3_nan;

    // Increment on above-half, or on an exact half when the LSB is odd.
    always_comb begin
        round_up = s2_g & (s2_r | s2_s | s2_mag[0]);
        s3_mag_n = s2_mag + MAG_W'(round_up);
    end

    // Stage 3 register; the spare top magnitude bit holds any rounding carry.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s3_valid <= 1'b0;
            s3_sign  <= 1'b0;
            s3_mag   <= '0;
            s3_ovf   <= 1'b0;
            s3_inf   <= 1'b0;
            s3_nan   <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sign <= s2_sign;
                s3_mag  <= s3_mag_n;
                s3_ovf  <= s2_ovf;
                s3_inf  <= s2_inf;
                s3_nan  <= s2_nan;
            end
        end
    end

    // ---------------- stage 4: sign and saturate ----------------
    logic [MAG_W-1:0]    neg_mag;
    logic [OUT_W-1:0]    res_n;
    logic                sat_n;

    // Apply sign, clamp out-of-range magnitudes, and map Inf/NaN to fixed codes.
    always_comb begin
        neg_mag = -s3_mag;
        res_n   = '0;
        sat_n   = 1'b0;
        if (s3_nan) begin
            res_n = '0;
            sat_n = 1'b1;
        end else if (s3_inf) begin
            res_n = s3_sign ? MIN_VAL : MAX_VAL;
            sat_n = 1'b1;
        end else if (!s3_sign) begin
            if (s3_ovf || (s3_mag >= LIM)) begin
                res_n = MAX_VAL;
                sat_n = 1'b1;
            end else begin
                res_n = s3_mag[OUT_W-1:0];
            end
        end else begin
            if (s3_ovf || (s3_mag > LIM)) begin
                res_n = MIN_VAL;
                sat_n = 1'b1;
            end else if (s3_mag == LIM) begin
                res_n = MIN_VAL;
            end else begin
                res_n = neg_mag[OUT_W-1:0];
            end
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dout_valid <= 1'b0;
            dout       <= '0;
            dout_sat   <= 1'b0;
        end else begin
            dout_valid <= s3_valid;
            if (s3_valid) begin
                dout     <= res_n;
                dout_sat <= sat_n;
            end
        end
    end

endmodule

// File: tb/tb_float_to_int_nb.sv
// Directed-vector bench for float_to_int_nb: one 16.0 instance and one 16.4 instance.
module tb_float_to_int_nb;

    typedef struct {
        logic [31:0] din;
        logic [15:0] dout;
        logic        sat;
        string       name;
    } vec_t;

    localparam int NV = 22;
    localparam int NS = 15;

    logic        clk;
    logic        nrst;
    logic [31:0] din;
    logic        din_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_sat;

    logic [31:0] din4;
    logic        din_valid4;
    logic [15:0] dout4;
    logic        dout_valid4;
    logic        dout_sat4;

    int checks;
    int failures;

    vec_t vecs [NV];
    vec_t vecs4 [3];

    logic        stim_valid [NS];
    int          stim_idx   [NS];

    float_to_int_nb #(.OUT_W(16), .FRAC_W(0)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sat   (dout_sat)
    );

    float_to_int_nb #(.OUT_W(16), .FRAC_W(4)) dut_f4 (
        .clk        (clk),
        .nrst       (nrst),
        .din        (din4),
        .din_valid  (din_valid4),
        .dout       (dout4),
        .dout_valid (dout_valid4),
        .dout_sat   (dout_sat4)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound so a broken DUT can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Drive one operand for one cycle, then wait until just before it should emerge.
    task automatic applyStimulus(input logic f4, input logic [31:0] value);
        @(negedge clk);
        if (f4) begin din4 = value; din_valid4 = 1'b1; end
        else    begin din  = value; din_valid  = 1'b1; end
        @(negedge clk);
        din_valid  = 1'b0;
        din_valid4 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One isolated operand: no output after 3 edges, result exactly after the 4th.
    task automatic runVector(input logic f4, input vec_t v);
        applyStimulus(f4, v.din);
        checkOutput({v.name, "_early"}, 32'(f4 ? dout_valid4 : dout_valid), 32'(0));
        @(negedge clk);
        checkOutput({v.name, "_valid"}, 32'(f4 ? dout_valid4 : dout_valid), 32'(1));
        checkOutput({v.name, "_dout"},  32'(f4 ? dout4 : dout),              32'(v.dout));
        checkOutput({v.name, "_sat"},   32'(f4 ? dout_sat4 : dout_sat),      32'(v.sat));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        nrst       = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        din4       = '0;
        din_valid4 = 1'b0;

        vecs[0]  = '{32'h40200000, 16'h0002, 1'b0, "tie_2p5"};
        vecs[1]  = '{32'h40600000, 16'h0004, 1'b0, "tie_3p5"};
        vecs[2]  = '{32'hC0200000, 16'hFFFE, 1'b0, "tie_m2p5"};
        vecs[3]  = '{32'h3F000000, 16'h0000, 1'b0, "half"};
        vecs[4]  = '{32'h3F400000, 16'h0001, 1'b0, "p0p75"};
        vecs[5]  = '{32'h80000000, 16'h0000, 1'b0, "neg_zero"};
        vecs[6]  = '{32'h00000001, 16'h0000, 1'b0, "denorm"};
        vecs[7]  = '{32'h46FFFE00, 16'h7FFF, 1'b0, "max_exact"};
        vecs[8]  = '{32'h46FFFF00, 16'h7FFF, 1'b1, "max_round_carry"};
        vecs[9]  = '{32'h47000000, 16'h7FFF, 1'b1, "pos_32768"};
        vecs[10] = '{32'hC7000000, 16'h8000, 1'b0, "min_exact"};
        vecs[11] = '{32'hC7000080, 16'h8000, 1'b0, "min_tie_even"};
        vecs[12] = '{32'h7F800000, 16'h7FFF, 1'b1, "pos_inf"};
        vecs[13] = '{32'hFF800000, 16'h8000, 1'b1, "neg_inf"};
        vecs[14] = '{32'h7FC00000, 16'h0000, 1'b1, "nan"};
        vecs[15] = '{32'h42C80000, 16'h0064, 1'b0, "hundred"};
        vecs[16] = '{32'hBF400000, 16'hFFFF, 1'b0, "m0p75"};
        vecs[17] = '{32'hC7000100, 16'h8000, 1'b1, "m32769"};
        vecs[18] = '{32'h501502F9, 16'h7FFF, 1'b1, "big_pos"};
        vecs[19] = '{32'hFFC00000, 16'h0000, 1'b1, "neg_nan"};
        vecs[20] = '{32'h3FC00000, 16'h0002, 1'b0, "tie_1p5"};
        vecs[21] = '{32'hC0600000, 16'hFFFC, 1'b0, "tie_m3p5"};

        vecs4[0] = '{32'h3FC00000, 16'h0018, 1'b0, "f4_1p5"};
        vecs4[1] = '{32'h3D000000, 16'h0000, 1'b0, "f4_tie_zero"};
        vecs4[2] = '{32'hBD400000, 16'hFFFF, 1'b0, "f4_m0p046875"};

        // 8 back-to-back, 3 idle, 4 back-to-back
        for (int i = 0; i < NS; i++) begin
            stim_valid[i] = (i < 8) || (i >= 11);
            stim_idx[i]   = (i * 5 + 3) % NV;
        end

        // Reset state
        #12;
        checkOutput("reset_valid", 32'(dout_valid), 32'(0));
        checkOutput("reset_dout",  32'(dout),       32'(0));
        checkOutput("reset_sat",   32'(dout_sat),   32'(0));
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Isolated vectors
        for (int i = 0; i < NV; i++) runVector(1'b0, vecs[i]);
        for (int i = 0; i < 3; i++)  runVector(1'b1, vecs4[i]);

        // Streaming: at negedge m check the operand driven at negedge m-4, then drive m.
        @(negedge clk);
        for (int m = 0; m < NS + 5; m++) begin
            if (m >= 4 && (m - 4) < NS) begin
                checkOutput($sformatf("stream%0d_valid", m - 4), 32'(dout_valid), 32'(stim_valid[m-4]));
                if (stim_valid[m-4]) begin
                    checkOutput($sformatf("stream%0d_dout", m - 4), 32'(dout),     32'(vecs[stim_idx[m-4]].dout));
                    checkOutput($sformatf("stream%0d_sat", m - 4),  32'(dout_sat), 32'(vecs[stim_idx[m-4]].sat));
                end
            end else begin
                checkOutput($sformatf("stream_idle%0d_valid", m), 32'(dout_valid), 32'(0));
            end
            if (m < NS) begin
                din       = stim_valid[m] ? vecs[stim_idx[m]].din : 32'h7F800000;
                din_valid = stim_valid[m];
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
        end

        // Reset mid-stream while results are emerging
        for (int m = 0; m < 7; m++) begin
            din       = vecs[m + 7].din;
            din_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("pre_reset_valid", 32'(dout_valid), 32'(1));
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("midreset_valid", 32'(dout_valid), 32'(0));
        checkOutput("midreset_dout",  32'(dout),       32'(0));
        checkOutput("midreset_sat",   32'(dout_sat),   32'(0));
        @(negedge clk);
        din_valid = 1'b0;
        nrst      = 1'b1;
        for (int m = 0; m < 6; m++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset%0d_valid", m), 32'(dout_valid), 32'(0));
        end

        // Pipeline still works after the flush
        runVector(1'b0, vecs[1]);
        runVector(1'b0, vecs[17]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
